// File: rtl/cacheline_arbiter.sv
// Arbitrates the single cacheline memory port between the I-cache and the D-cache.
// One whole line transaction is granted at a time. Every output is driven straight from a flop.
module cacheline_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter bit DCACHE_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(5'h1f);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 1 = D-cache was granted last
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic                m_read_q, m_read_d;
  logic                m_write_q, m_write_d;
  logic [LINE_W-1:0]   m_wdata_q, m_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic                i_resp_q, i_resp_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_resp_q, d_resp_d;
  logic                d_req;
  logic                grant_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_addr_d     = m_addr_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    i_resp_d     = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_resp_d     = 1'b0;
    d_req        = d_read || d_write;
    grant_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          // On a tie D wins when it has priority or when I was served last.
          grant_d      = d_req && (!i_read || DCACHE_PRIO || !last_grant_q);
          last_grant_d = grant_d;
          if (grant_d) begin
            state_d   = BUSY_D;
            m_addr_d  = d_addr & LINE_MASK;
            m_write_d = d_write;
            m_read_d  = !d_write;
            m_wdata_d = d_write ? d_wdata : '0;
          end else begin
            state_d   = BUSY_I;
            m_addr_d  = i_addr & LINE_MASK;
            m_write_d = 1'b0;
            m_read_d  = 1'b1;
            m_wdata_d = '0;
          end
        end
      end
      BUSY_I: begin
        if (m_resp) begin
          i_rdata_d = m_rdata;
          i_resp_d  = 1'b1;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = DONE;
        end
      end
      BUSY_D: begin
        if (m_resp) begin
          d_rdata_d = m_rdata;
          d_resp_d  = 1'b1;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      m_addr_q     <= '0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_wdata_q    <= '0;
      i_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_rdata_q    <= '0;
      d_resp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_addr_q     <= m_addr_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_wdata_q    <= m_wdata_d;
      i_rdata_q    <= i_rdata_d;
      i_resp_q     <= i_resp_d;
      d_rdata_q    <= d_rdata_d;
      d_resp_q     <= d_resp_d;
    end
  end

  // Protocol checks; a response that lands while reset is held is expected and ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $error("cacheline_arbiter: d_read and d_write asserted together");
      assert (!m_resp || state_q == BUSY_I || state_q == BUSY_D)
        else $error("cacheline_arbiter: m_resp with no transaction in flight");
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_resp  = i_resp_q;
  assign d_rdata = d_rdata_q;
  assign d_resp  = d_resp_q;
  assign m_addr  = m_addr_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_wdata = m_wdata_q;

endmodule
